// File: rtl/clz.sv
// Leading-zero counter: vout flags a nonzero input, pout is the number of
// zeros above the highest set bit (0 when the input is zero).
module clz #(
  parameter int bits_in = 8,
  parameter int LW      = (bits_in > 1) ? $clog2(bits_in) : 1
) (
  input  logic [bits_in-1:0] vin,
  output logic               vout,
  output logic [LW-1:0]      pout
);

  // Scanning upward lets the highest set bit be the last one written.
  always_comb begin
    vout = |vin;
    pout = '0;
    for (int i = 0; i < bits_in; i++) begin
      if (vin[i]) begin
        pout = LW'(bits_in - 1 - i);
      end
    end
  end

endmodule

// File: rtl/norm_shift_pipe.sv
// Two-stage normalisation pipe: stage A captures the operand with its
// leading-zero count, stage B shifts the magnitude and adjusts the exponent.
module norm_shift_pipe #(
  parameter  int WIDTH     = 8,
  parameter  int EXP_WIDTH = 8,
  localparam int LZW       = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [EXP_WIDTH-1:0] in_exp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic [LZW-1:0]       out_shift,
  output logic                 out_zero,
  output logic                 out_denorm
);

  localparam int CW = (LZW > EXP_WIDTH) ? LZW : EXP_WIDTH;

  logic                 aValid_q;
  logic [WIDTH-1:0]     aData_q;
  logic [EXP_WIDTH-1:0] aExp_q;
  logic [LZW-1:0]       aLz_q;
  logic                 aNz_q;

  logic                 bValid_q;
  logic [WIDTH-1:0]     bData_q,  bData_d;
  logic [EXP_WIDTH-1:0] bExp_q,   bExp_d;
  logic [LZW-1:0]       bShift_q, bShift_d;
  logic                 bZero_q,  bZero_d;
  logic                 bDenorm_q, bDenorm_d;

  logic           inNz;
  logic [LZW-1:0] inLz;
  logic           advA, advB;
  logic [CW-1:0]  lzExt, expExt, shCw, expDiff;

  clz #(.bits_in(WIDTH), .LW(LZW)) u_clz (
    .vin  (in_data),
    .vout (inNz),
    .pout (inLz)
  );

  assign advB     = !bValid_q || out_ready;
  assign advA     = !aValid_q || advB;
  assign in_ready = advA;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aValid_q <= 1'b0;
      aData_q  <= '0;
      aExp_q   <= '0;
      aLz_q    <= '0;
      aNz_q    <= 1'b0;
    end else if (advA) begin
      aValid_q <= in_valid;
      aData_q  <= in_data;
      aExp_q   <= in_exp;
      aLz_q    <= inLz;
      aNz_q    <= inNz;
    end
  end

  // The shift is capped by the exponent so the result saturates into the
  // denormal range instead of underflowing.
  always_comb begin
    lzExt     = CW'(aLz_q);
    expExt    = CW'(aExp_q);
    shCw      = (lzExt < expExt) ? lzExt : expExt;
    expDiff   = expExt - shCw;
    bData_d   = '0;
    bExp_d    = '0;
    bShift_d  = '0;
    bZero_d   = 1'b1;
    bDenorm_d = 1'b0;
    if (aNz_q) begin
      bShift_d  = LZW'(shCw);
      bData_d   = aData_q << bShift_d;
      bExp_d    = EXP_WIDTH'(expDiff);
      bZero_d   = 1'b0;
      bDenorm_d = (bExp_d == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bValid_q  <= 1'b0;
      bData_q   <= '0;
      bExp_q    <= '0;
      bShift_q  <= '0;
      bZero_q   <= 1'b0;
      bDenorm_q <= 1'b0;
    end else if (advB) begin
      bValid_q  <= aValid_q;
      bData_q   <= bData_d;
      bExp_q    <= bExp_d;
      bShift_q  <= bShift_d;
      bZero_q   <= bZero_d;
      bDenorm_q <= bDenorm_d;
    end
  end

  assign out_valid  = bValid_q;
  assign out_data   = bData_q;
  assign out_exp    = bExp_q;
  assign out_shift  = bShift_q;
  assign out_zero   = bZero_q;
  assign out_denorm = bDenorm_q;

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Scoreboard bench for norm_shift_pipe: expected results are queued on input
// transfer and compared in order on output transfer.
module tb_norm_shift_pipe;

  localparam int WIDTH     = 8;
  localparam int EXP_WIDTH = 8;
  localparam int LZW       = 3;

  typedef struct packed {
    logic [WIDTH-1:0]     data;
    logic [EXP_WIDTH-1:0] exp;
    logic [LZW-1:0]       shift;
    logic                 zero;
    logic                 denorm;
  } res_t;

  typedef struct {
    res_t res;
    int   pushCycle;
  } sb_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [EXP_WIDTH-1:0] in_exp;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [EXP_WIDTH-1:0] out_exp;
  logic [LZW-1:0]       out_shift;
  logic                 out_zero;
  logic                 out_denorm;

  int    compared   = 0;
  int    mismatched = 0;
  int    cycle      = 0;
  bit    latencyCheck;
  bit    prevStall;
  logic [31:0] prevOut;
  sb_t   sbQ[$];

  always #5 clk = ~clk;

  norm_shift_pipe #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_exp     (in_exp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_exp    (out_exp),
    .out_shift  (out_shift),
    .out_zero   (out_zero),
    .out_denorm (out_denorm)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // Independent reference: count zeros from the MSB, then clamp by exponent.
  function automatic res_t model(input logic [WIDTH-1:0] d, input logic [EXP_WIDTH-1:0] e);
    res_t r;
    int   lz;
    int   sh;
    r = '0;
    if (d == '0) begin
      r.zero = 1'b1;
      return r;
    end
    lz = 0;
    while (d[WIDTH-1-lz] == 1'b0) lz++;
    sh = (lz < int'(e)) ? lz : int'(e);
    r.data   = d << sh;
    r.exp    = EXP_WIDTH'(int'(e) - sh);
    r.shift  = LZW'(sh);
    r.denorm = (r.exp == '0);
    return r;
  endfunction

  function automatic logic [31:0] observedNow();
    res_t r;
    r.data   = out_data;
    r.exp    = out_exp;
    r.shift  = out_shift;
    r.zero   = out_zero;
    r.denorm = out_denorm;
    return {10'd0, out_valid, r};
  endfunction

  // One cycle: drive after the falling edge, sample 1ns later, well clear of
  // the rising edge where both transfers happen.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic [EXP_WIDTH-1:0] e,
                               input logic rdy, output logic accepted);
    sb_t  ent;
    logic [31:0] nowOut;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_exp    = e;
    out_ready = rdy;
    #1;
    cycle++;
    nowOut = observedNow();
    if (prevStall) checkOutput("stallHold", nowOut, prevOut);
    prevStall = out_valid && !out_ready;
    prevOut   = nowOut;
    if (out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedOut", 32'(out_valid), 32'd0);
      end else begin
        ent = sbQ.pop_front();
        checkOutput("result", nowOut, {10'd0, 1'b1, ent.res});
        if (latencyCheck) checkOutput("latency", 32'(cycle - ent.pushCycle), 32'd2);
      end
    end
    accepted = v && in_ready;
    if (accepted) begin
      ent.res       = model(d, e);
      ent.pushCycle = cycle;
      sbQ.push_back(ent);
    end
  endtask

  task automatic drain(input int maxCycles);
    logic acc;
    for (int i = 0; i < maxCycles && sbQ.size() != 0; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, acc);
    end
    applyStimulus(1'b0, '0, '0, 1'b1, acc);
    checkOutput("drainEmpty", 32'(sbQ.size()), 32'd0);
  endtask

  initial begin
    logic acc;
    int   idx;
    int   accepted;
    bit   sawBackpressure;
    logic [7:0] dirData [6];
    logic [7:0] dirExp  [6];

    dirData = '{8'h16, 8'h00, 8'hFF, 8'h01, 8'h01, 8'h10};
    dirExp  = '{8'd20, 8'd5,  8'd9,  8'd3,  8'd7,  8'd0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_exp = '0; out_ready = 1'b1;
    prevStall = 1'b0; prevOut = '0; latencyCheck = 1'b1;
    #12;
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstInReady", 32'(in_ready), 32'd1);
    checkOutput("rstOutRegs", observedNow(), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed operands with a bubble in the middle");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, dirData[i], dirExp[i], 1'b1, acc);
      checkOutput("dirAccept", 32'(acc), 32'd1);
      if (i == 2) applyStimulus(1'b0, 8'hAA, 8'd1, 1'b1, acc);
    end
    drain(10);

    $display("[TB] backpressure burst");
    latencyCheck = 1'b0;
    idx = 0;
    sawBackpressure = 1'b0;
    for (int t = 1; t <= 40 && (idx < 5 || sbQ.size() != 0); t++) begin
      applyStimulus(idx < 5, 8'(idx + 1), 8'd10, !(t >= 2 && t <= 6), acc);
      if (idx < 5 && !in_ready) begin
        sawBackpressure = 1'b1;
        checkOutput("bpHeld", 32'(sbQ.size()), 32'd2);
      end
      if (acc) idx++;
    end
    checkOutput("bpFell", 32'(sawBackpressure), 32'd1);
    checkOutput("bpAllIn", 32'(idx), 32'd5);
    drain(10);

    $display("[TB] reset mid-flight");
    applyStimulus(1'b1, 8'h03, 8'd6, 1'b0, acc);
    applyStimulus(1'b1, 8'h05, 8'd6, 1'b0, acc);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b0, acc);
    checkOutput("preRstFull", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
    checkOutput("midRstInReady", 32'(in_ready), 32'd1);
    sbQ.delete();
    prevStall = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    latencyCheck = 1'b1;
    applyStimulus(1'b1, 8'h40, 8'd4, 1'b1, acc);
    checkOutput("postRstAccept", 32'(acc), 32'd1);
    drain(10);

    $display("[TB] random stream");
    latencyCheck = 1'b0;
    accepted = 0;
    for (int c = 0; c < 60000 && accepted < 10000; c++) begin
      logic [7:0] rd;
      logic [7:0] re;
      rd = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rd = rd >> $urandom_range(0, 7);
      re = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, rd, re, $urandom_range(0, 3) != 0, acc);
      if (acc) accepted++;
    end
    checkOutput("randAccepted", 32'(accepted), 32'd10000);
    drain(20);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
